// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock through a shared round datapath,
// key schedule expanded on the fly, valid/ready handshake on both sides.
module aes_round_engine #(
   parameter int NR        = 10,
   parameter bit FINAL_MIX = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] IN_DATA,
   input  logic [127:0] IN_KEY,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] OUT_DATA,
   output logic         BUSY,
   output logic [3:0]   ROUND
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t        state_q;
   state_t        state_d;
   logic [127:0]  state_r;
   logic [127:0]  key_r;
   logic [127:0]  key_next;
   logic [127:0]  sub_out;
   logic [127:0]  shift_out;
   logic [127:0]  mix_out;
   logic [127:0]  round_out;
   logic [31:0]   w0, w1, w2, w3, temp, n0, n1, n2, n3;
   logic [3:0]    round_nxt;
   logic [7:0]    rcon;
   logic          last;
   logic          accept;
   logic          bypass_mix;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign IN_READY   = !rst && (state_q == IDLE || (state_q == DONE && OUT_READY));
   assign accept     = IN_VALID && IN_READY;
   assign BUSY       = (state_q == RUN);
   assign round_nxt  = ROUND + 4'd1;
   assign last       = (round_nxt == 4'(NR));
   assign bypass_mix = last && !FINAL_MIX;

   always_comb begin
      rcon = 8'h00;
      case (round_nxt)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Next round key: SubWord(RotWord(w3)) ^ rcon feeds a ripple of XORs across the four words.
   assign w0       = key_r[127:96];
   assign w1       = key_r[95:64];
   assign w2       = key_r[63:32];
   assign w3       = key_r[31:0];
   assign temp     = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
   assign n0       = w0 ^ temp;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign key_next = {n0, n1, n2, n3};

   // Byte i sits at [127-8i]; row r of column c is byte 4c+r, so ShiftRows pulls from column c+r.
   always_comb begin
      sub_out   = '0;
      shift_out = '0;
      mix_out   = '0;
      round_out = '0;
      for (int i = 0; i < 16; i++) begin
         sub_out[127-8*i -: 8] = SBOX[state_r[127-8*i -: 8]];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_out[127-8*(4*c+r) -: 8] = sub_out[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_out[127-32*c -: 32] = mix_column(shift_out[127-32*c -: 32]);
      end
      round_out = (bypass_mix ? shift_out : mix_out) ^ key_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE: begin
            if (OUT_READY) state_d = IN_VALID ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A DONE-state accept loads the new block on the same edge the result is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= '0;
         key_r     <= '0;
         ROUND     <= '0;
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         if (accept) begin
            state_r <= IN_DATA ^ IN_KEY;
            key_r   <= IN_KEY;
            ROUND   <= '0;
         end else if (state_q == RUN) begin
            state_r <= round_out;
            key_r   <= key_next;
            ROUND   <= round_nxt;
         end
         if (state_q == RUN && last) begin
            OUT_DATA  <= round_out;
            OUT_VALID <= 1'b1;
         end else if (state_q == DONE && OUT_READY) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule
